bsg_manycore_eva_to_npa_pipe: RTL

Pipelined, parameterised EVA-to-NPA translator for endpoints that issue remote requests at full rate, such as accelerators and DMA engines.
- Classifies a 32-bit EVA as DRAM, global, tile-group or tile-group-shared, and produces {x_cord, y_cord, EPA}.
- Adds a valid/ready input and valid/yumi output handshake, runtime-writable tile-group config registers, and a configurable number of vcache rows (1 = top only, 2 = top and bottom).
- Sits between the endpoint request generator and the network link.

---
 rtl/bsg_manycore_pkg.sv | 70 +++++++
 rtl/bsg_manycore_eva_to_npa_shared_hash.sv | 50 +++++
 rtl/bsg_manycore_eva_to_npa_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore EVA-to-NPA translator: remote address
// field layouts, EVA classes, and the tile-group config snapshot.
package bsg_manycore_pkg;

  // Coordinate width held in the config snapshot; ports are cast to/from this.
  localparam int cfg_cord_width_gp = 8;

  localparam logic [1:0] global_remote_prefix_gp     = 2'b01;
  localparam logic [2:0] tile_group_remote_prefix_gp = 3'b001;
  localparam logic [4:0] shared_remote_prefix_gp     = 5'b00001;

  typedef struct packed {
    logic [1:0]  remote;
    logic [5:0]  y_cord;
    logic [5:0]  x_cord;
    logic [15:0] addr;
    logic [1:0]  low_bits;
  } bsg_manycore_global_addr_s;

  typedef struct packed {
    logic [2:0]  remote;
    logic [5:0]  y_cord;
    logic [5:0]  x_cord;
    logic [14:0] addr;
    logic [1:0]  low_bits;
  } bsg_manycore_tile_group_addr_s;

  typedef struct packed {
    logic [4:0]  remote;
    logic [3:0]  hash;
    logic [20:0] offset;
    logic [1:0]  low_bits;
  } bsg_manycore_shared_addr_s;

  typedef enum logic [2:0] {
    e_eva_dram,
    e_eva_global,
    e_eva_tg,
    e_eva_shared,
    e_eva_invalid
  } eva_class_e;

  typedef struct packed {
    logic [cfg_cord_width_gp-1:0] tgo_x;
    logic [cfg_cord_width_gp-1:0] tgo_y;
    logic [2:0]                   dim_x_width;
    logic [2:0]                   dim_y_width;
    logic                         dram_enable;
  } tg_cfg_s;

  // Priority-ordered decode of the EVA's top bits.
  function automatic eva_class_e classify_eva(input logic [31:0] eva);
    if (eva[31])
      return e_eva_dram;
    else if (eva[31:30] == global_remote_prefix_gp)
      return e_eva_global;
    else if (eva[31:29] == tile_group_remote_prefix_gp)
      return e_eva_tg;
    else if (eva[31:27] == shared_remote_prefix_gp)
      return e_eva_shared;
    else
      return e_eva_invalid;
  endfunction

  // Tile-group dimensions wider than 32 are clamped to 32.
  function automatic logic [2:0] sat_dim(input logic [2:0] w);
    return (w > 3'd5) ? 3'd5 : w;
  endfunction

endpackage

// File: rtl/bsg_manycore_eva_to_npa_shared_hash.sv
// Combinational mapping of a tile-group-shared EVA onto a tile and a
// DMEM word address. The hash field selects how many low offset bits stay
// inside one tile before the tile index bits are extracted.
module bsg_manycore_eva_to_npa_shared_hash
  import bsg_manycore_pkg::*;
#(
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 28,
  parameter int x_cord_width_p    = 7,
  parameter int y_cord_width_p    = 7,
  parameter int dmem_start_addr_p = 'h400
) (
  input  logic [data_width_p-1:0]   eva_i,
  input  logic [x_cord_width_p-1:0] tgo_x_i,
  input  logic [y_cord_width_p-1:0] tgo_y_i,
  input  logic [2:0]                dim_x_width_i,
  input  logic [2:0]                dim_y_width_i,
  output logic [x_cord_width_p-1:0] x_o,
  output logic [y_cord_width_p-1:0] y_o,
  output logic [addr_width_p-1:0]   epa_o
);

  bsg_manycore_shared_addr_s sh;
  logic [3:0]  h;
  logic [20:0] off;
  logic [4:0]  dxy;
  logic [5:0]  hi_shift;
  logic [20:0] tile;
  logic [20:0] tile_x;
  logic [20:0] tile_y;
  logic [20:0] word;

  assign sh       = bsg_manycore_shared_addr_s'(eva_i[31:0]);
  assign h        = sh.hash;
  assign off      = sh.offset;
  assign dxy      = {2'b00, dim_x_width_i} + {2'b00, dim_y_width_i};
  assign hi_shift = {2'b00, h} + {1'b0, dxy};

  assign tile   = (off >> h) & ((21'd1 << dxy) - 21'd1);
  assign tile_x = tile & ((21'd1 << dim_x_width_i) - 21'd1);
  assign tile_y = tile >> dim_x_width_i;

  // Drop the tile-index bits and close the gap above the hash-selected low bits.
  assign word = ((off >> hi_shift) << h) | (off & ((21'd1 << h) - 21'd1));

  assign x_o   = tgo_x_i + x_cord_width_p'(tile_x);
  assign y_o   = tgo_y_i + y_cord_width_p'(tile_y);
  assign epa_o = addr_width_p'(word) + addr_width_p'(dmem_start_addr_p);

endmodule

// File: rtl/bsg_manycore_eva_to_npa_pipe.sv
// Two-stage pipelined EVA-to-NPA translator with valid/ready input and
// valid/yumi output. Stage 1 captures the EVA, its class and a config
// snapshot; stage 2 holds the translated NPA until it is consumed.
// Optional build macro BSG_MANYCORE_EVA_TO_NPA_FAULT_CNT_EN adds a
// saturating count of consumed invalid translations on fault_count_o.
module bsg_manycore_eva_to_npa_pipe
  import bsg_manycore_pkg::*;
#(
  parameter int data_width_p                 = 32,
  parameter int addr_width_p                 = 28,
  parameter int x_cord_width_p               = 7,
  parameter int y_cord_width_p               = 7,
  parameter int num_tiles_x_p                = 16,
  parameter int num_tiles_y_p                = 8,
  parameter int num_vcache_rows_p            = 2,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int vcache_size_p                = 4096,
  parameter int dmem_start_addr_p            = 'h400
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      cfg_v_i,
  input  logic [x_cord_width_p-1:0] cfg_tgo_x_i,
  input  logic [y_cord_width_p-1:0] cfg_tgo_y_i,
  input  logic [2:0]                cfg_tg_dim_x_width_i,
  input  logic [2:0]                cfg_tg_dim_y_width_i,
  input  logic                      cfg_dram_enable_i,
  input  logic                      v_i,
  input  logic [data_width_p-1:0]   eva_i,
  output logic                      ready_o,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [x_cord_width_p-1:0] x_cord_o,
  output logic [y_cord_width_p-1:0] y_cord_o,
  output logic [addr_width_p-1:0]   epa_o,
  output logic                      is_invalid_addr_o,
  output logic [15:0]               fault_count_o
);

  localparam int lg_x_lp    = $clog2(num_tiles_x_p);
  localparam int blk_w_lp   = $clog2(vcache_block_size_in_words_p);
  localparam int bank_w_lp  = $clog2(num_tiles_x_p * num_vcache_rows_p);
  localparam int vc_w_lp    = $clog2(vcache_size_p);
  localparam logic [y_cord_width_p-1:0] bottom_y_lp = y_cord_width_p'(num_tiles_y_p + 1);

  tg_cfg_s cfg_r;

  logic                    s1_v;
  logic [data_width_p-1:0] s1_eva;
  eva_class_e              s1_class;
  tg_cfg_s                 s1_cfg;

  logic                      s2_v;
  logic                      s2_en;
  logic [x_cord_width_p-1:0] s2_x;
  logic [y_cord_width_p-1:0] s2_y;
  logic [addr_width_p-1:0]   s2_epa;
  logic                      s2_inv;

  logic [x_cord_width_p-1:0] nx;
  logic [y_cord_width_p-1:0] ny;
  logic [addr_width_p-1:0]   nepa;
  logic                      ninv;

  logic [x_cord_width_p-1:0] sh_x;
  logic [y_cord_width_p-1:0] sh_y;
  logic [addr_width_p-1:0]   sh_epa;

  logic [31:0]                   dram_blk;
  bsg_manycore_global_addr_s     g_addr;
  bsg_manycore_tile_group_addr_s tg_addr;

  assign s2_en   = ~s2_v | yumi_i;
  assign ready_o = ~s1_v | s2_en;

  // Config registers; dims saturate on write.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cfg_r <= '0;
    end else if (cfg_v_i) begin
      cfg_r.tgo_x       <= cfg_cord_width_gp'(cfg_tgo_x_i);
      cfg_r.tgo_y       <= cfg_cord_width_gp'(cfg_tgo_y_i);
      cfg_r.dim_x_width <= sat_dim(cfg_tg_dim_x_width_i);
      cfg_r.dim_y_width <= sat_dim(cfg_tg_dim_y_width_i);
      cfg_r.dram_enable <= cfg_dram_enable_i;
    end
  end

  // Stage 1: capture EVA, class and config snapshot on acceptance.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      s1_v     <= 1'b0;
      s1_eva   <= '0;
      s1_class <= e_eva_invalid;
      s1_cfg   <= '0;
    end else if (ready_o) begin
      s1_v <= v_i;
      if (v_i) begin
        s1_eva   <= eva_i;
        s1_class <= classify_eva(eva_i[31:0]);
        s1_cfg   <= cfg_r;
      end
    end
  end

  bsg_manycore_eva_to_npa_shared_hash #(
    .data_width_p      (data_width_p),
    .addr_width_p      (addr_width_p),
    .x_cord_width_p    (x_cord_width_p),
    .y_cord_width_p    (y_cord_width_p),
    .dmem_start_addr_p (dmem_start_addr_p)
  ) shared_hash (
    .eva_i         (s1_eva),
    .tgo_x_i       (x_cord_width_p'(s1_cfg.tgo_x)),
    .tgo_y_i       (y_cord_width_p'(s1_cfg.tgo_y)),
    .dim_x_width_i (s1_cfg.dim_x_width),
    .dim_y_width_i (s1_cfg.dim_y_width),
    .x_o           (sh_x),
    .y_o           (sh_y),
    .epa_o         (sh_epa)
  );

  assign dram_blk = {1'b0, s1_eva[30:0]} >> (2 + blk_w_lp);
  assign g_addr   = bsg_manycore_global_addr_s'(s1_eva[31:0]);
  assign tg_addr  = bsg_manycore_tile_group_addr_s'(s1_eva[31:0]);

  // Translate the stage-1 EVA according to its class.
  always_comb begin
    nx   = '0;
    ny   = '0;
    nepa = '0;
    ninv = 1'b0;
    unique case (s1_class)
      e_eva_dram: begin
        if (s1_cfg.dram_enable) begin
          nx = x_cord_width_p'(dram_blk[lg_x_lp-1:0]);
          if (num_vcache_rows_p == 2 && dram_blk[bank_w_lp-1])
            ny = bottom_y_lp;
          nepa = addr_width_p'((dram_blk >> bank_w_lp) << blk_w_lp)
               | addr_width_p'(s1_eva[2 +: blk_w_lp]);
        end else if (s1_eva[30]) begin
          ny   = y_cord_width_p'(1);
          nepa = {1'b1, s1_eva[2 +: addr_width_p-1]};
        end else begin
          nx = x_cord_width_p'(s1_eva[2+vc_w_lp +: lg_x_lp]);
          if (num_vcache_rows_p == 2 && s1_eva[2+vc_w_lp+lg_x_lp])
            ny = bottom_y_lp;
          nepa = addr_width_p'(s1_eva[2 +: vc_w_lp]);
        end
      end
      e_eva_global: begin
        nx   = x_cord_width_p'(g_addr.x_cord);
        ny   = y_cord_width_p'(g_addr.y_cord);
        nepa = addr_width_p'(g_addr.addr);
      end
      e_eva_tg: begin
        nx   = x_cord_width_p'(tg_addr.x_cord) + x_cord_width_p'(s1_cfg.tgo_x);
        ny   = y_cord_width_p'(tg_addr.y_cord) + y_cord_width_p'(s1_cfg.tgo_y);
        nepa = addr_width_p'(tg_addr.addr);
      end
      e_eva_shared: begin
        nx   = sh_x;
        ny   = sh_y;
        nepa = sh_epa;
      end
      default: begin
        ninv = 1'b1;
      end
    endcase
  end

  // Stage 2: hold the NPA until consumed; advance when empty or yumi.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      s2_v   <= 1'b0;
      s2_x   <= '0;
      s2_y   <= '0;
      s2_epa <= '0;
      s2_inv <= 1'b0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_x   <= nx;
        s2_y   <= ny;
        s2_epa <= nepa;
        s2_inv <= ninv;
      end
    end
  end

  assign v_o               = s2_v;
  assign x_cord_o          = s2_x;
  assign y_cord_o          = s2_y;
  assign epa_o             = s2_epa;
  assign is_invalid_addr_o = s2_inv;

`ifdef BSG_MANYCORE_EVA_TO_NPA_FAULT_CNT_EN
  logic [15:0] fault_cnt_r;

  // Count consumed invalid translations, saturating.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      fault_cnt_r <= '0;
    else if (s2_v && yumi_i && s2_inv && fault_cnt_r != 16'hFFFF)
      fault_cnt_r <= fault_cnt_r + 16'd1;
  end

  assign fault_count_o = fault_cnt_r;
`else
  assign fault_count_o = '0;
`endif

endmodule
